boot_run_ctrl: RTL and testbench

Boot and run sequencer for the single-cycle RISC-V core. It accepts a program image over a valid/ready stream and writes it word-by-word into instruction memory while holding the core in reset. It then releases the core and monitors its PC until the core halts, a cycle budget expires, or the host aborts. It sits between the host/test interface and the core's `reset` input and instruction-memory write port.

---
 rtl/boot_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_boot_run_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: boot and run sequencer for the single-cycle RISC-V core.
// It streams a program image into instruction memory while the core is held
// in reset. It then releases the core and watches its PC until the core halts
// (PC self-loop), the cycle budget runs out, or the host aborts.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               begin a load (sampled only in IDLE)
//   load_len            words to load (1..IMEM_DEPTH), sampled with start
//   cycle_budget        max RUN cycles, 0 = unlimited, sampled with start
//   abort               terminate LOAD/FLUSH/RUN
//   s_valid/s_data      program word stream; s_ready = state is LOAD
//   imem_we/addr/wdata  instruction-memory write port (registered)
//   core_pc             core PC_out
//   core_reset          core reset, 1 = core held
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   status              00 none, 01 halted, 10 timeout, 11 aborted/bad length
//   run_cycles          saturating count of RUN cycles
module boot_run_ctrl #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        load_len,
  input  logic [CNT_W-1:0]  cycle_budget,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       core_pc,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [6:0]       len_q;
  logic [CNT_W-1:0] budget_q;
  logic [6:0]       word_cnt;
  logic [31:0]      pc_prev;

  logic hs_c;
  logic len_ok_c;
  logic last_c;
  logic halt_c;
  logic tmo_c;

  // s_ready is the only unregistered output: a plain decode of LOAD.
  assign s_ready  = (state == S_LOAD);
  assign hs_c     = s_valid & s_ready;
  assign len_ok_c = (load_len != 7'd0) && (load_len <= 7'(IMEM_DEPTH));
  assign last_c   = (7'(word_cnt + 7'd1) == len_q);
  // Halt needs two completed RUN cycles so a stale pc_prev cannot match.
  assign halt_c   = (run_cycles >= CNT_W'(2)) && (core_pc == pc_prev);
  assign tmo_c    = (budget_q != '0) &&
                    (CNT_W'(run_cycles + CNT_W'(1)) == budget_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode; abort outranks handshake, halt and timeout
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = len_ok_c ? S_LOAD : S_DONE;
      end
      S_LOAD: begin
        if (abort)                next_state = S_DONE;
        else if (hs_c && last_c)  next_state = S_FLUSH;
      end
      S_FLUSH: begin
        next_state = abort ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort || halt_c || tmo_c) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      status     <= ST_NONE;
      run_cycles <= '0;
      len_q      <= '0;
      budget_q   <= '0;
      word_cnt   <= '0;
      pc_prev    <= '0;
    end else begin
      core_reset <= (next_state != S_RUN);
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
      imem_we    <= (state == S_LOAD) && hs_c && !abort;

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= load_len;
            budget_q   <= cycle_budget;
            word_cnt   <= '0;
            run_cycles <= '0;
            status     <= len_ok_c ? ST_NONE : ST_ABORT;
          end
        end
        S_LOAD: begin
          if (abort) begin
            status <= ST_ABORT;
          end else if (hs_c) begin
            imem_addr  <= ADDR_W'(word_cnt);
            imem_wdata <= s_data;
            word_cnt   <= 7'(word_cnt + 7'd1);
          end
        end
        S_FLUSH: begin
          if (abort) status <= ST_ABORT;
        end
        S_RUN: begin
          if (run_cycles != '1) run_cycles <= CNT_W'(run_cycles + CNT_W'(1));
          pc_prev <= core_pc;
          if (abort)       status <= ST_ABORT;
          else if (halt_c) status <= ST_HALT;
          else if (tmo_c)  status <= ST_TMO;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed self-checking bench for boot_run_ctrl.
module tb_boot_run_ctrl;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic [6:0]        load_len;
  logic [CNT_W-1:0]  cycle_budget;
  logic              abort;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       core_pc;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic [CNT_W-1:0]  run_cycles;

  int n_tests;
  int n_fail;

  boot_run_ctrl #(.IMEM_DEPTH(64), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .cycle_budget(cycle_budget), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_pc(core_pc),
    .core_reset(core_reset), .busy(busy), .done(done), .status(status),
    .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_s_ready"},    32'(s_ready),    32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_status"},     32'(status),     32'd0);
    check({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  // Start a load of n words (data = 0x11*(i+1)) with an optional s_valid gap
  // before word gap_at. Returns sampled in the first RUN cycle.
  task automatic do_load(input int n, input int gap_at, input int gap_len,
                         input logic [CNT_W-1:0] budget);
    start = 1'b1; load_len = 7'(n); cycle_budget = budget;
    tick();
    start = 1'b0;
    check("ld_ready_after_start", 32'(s_ready), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          s_valid = 1'b0;
          tick();
          check("gap_we", 32'(imem_we), 32'd0);
          check("gap_ready", 32'(s_ready), 32'd1);
        end
      end
      s_valid = 1'b1;
      s_data  = 32'h11 * 32'(i + 1);
      tick();
      check("ld_we", 32'(imem_we), 32'd1);
      check("ld_addr", 32'(imem_addr), 32'(i));
      check("ld_data", imem_wdata, 32'h11 * 32'(i + 1));
    end
    s_valid = 1'b0;
    // FLUSH cycle
    check("flush_ready", 32'(s_ready), 32'd0);
    check("flush_core_reset", 32'(core_reset), 32'd1);
    tick();
    check("run_core_reset", 32'(core_reset), 32'd0);
    check("run_we", 32'(imem_we), 32'd0);
  endtask

  initial begin
    int k;
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; load_len = '0; cycle_budget = '0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0; core_pc = '0;
    #3;
    check_reset_vals("rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // Back-to-back load of 4 words, then a program that self-loops at PC 8.
    do_load(4, -1, 0, '0);
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      core_pc = (i <= 3) ? 32'(4 * (i - 1)) : 32'd8;
      tick();
      if (done) begin k = i; break; end
    end
    check("halt_run_cycle", 32'(k), 32'd4);
    check("halt_status", 32'(status), 32'd1);
    check("halt_run_cycles", 32'(run_cycles), 32'd4);
    check("halt_core_reset", 32'(core_reset), 32'd1);
    check("halt_busy_in_done", 32'(busy), 32'd1);
    tick();
    check("halt_done_pulse", 32'(done), 32'd0);
    check("halt_busy_off", 32'(busy), 32'd0);
    check("halt_status_held", 32'(status), 32'd1);

    // Load with a 3-cycle gap before word index 2, non-halting program, budget 10.
    do_load(4, 2, 3, CNT_W'(10));
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      core_pc = 32'(4 * i);
      tick();
      if (done) begin k = i; break; end
    end
    check("tmo_run_cycle", 32'(k), 32'd10);
    check("tmo_status", 32'(status), 32'd2);
    check("tmo_run_cycles", 32'(run_cycles), 32'd10);
    tick();
    check("tmo_idle", 32'(busy), 32'd0);

    // Illegal lengths go straight to DONE with status 11.
    for (int j = 0; j < 2; j++) begin
      start = 1'b1; load_len = (j == 0) ? 7'd0 : 7'd65;
      tick();
      start = 1'b0;
      check("badlen_ready", 32'(s_ready), 32'd0);
      check("badlen_done", 32'(done), 32'd1);
      check("badlen_status", 32'(status), 32'd3);
      tick();
      check("badlen_idle", 32'(busy), 32'd0);
      check("badlen_ready_idle", 32'(s_ready), 32'd0);
    end

    // start during RUN is ignored; abort in RUN ends with status 11.
    do_load(1, -1, 0, '0);
    start = 1'b1; load_len = 7'd5; core_pc = 32'h100;
    tick();
    start = 1'b0; core_pc = 32'h104;
    check("run_start_ign_ready", 32'(s_ready), 32'd0);
    check("run_start_ign_core", 32'(core_reset), 32'd0);
    tick();
    check("run_still_running", 32'(done), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("run_abort_done", 32'(done), 32'd1);
    check("run_abort_status", 32'(status), 32'd3);
    check("run_abort_cycles", 32'(run_cycles), 32'd3);
    tick();

    // Abort during LOAD after 2 of 5 words; the coincident handshake is dropped.
    start = 1'b1; load_len = 7'd5; cycle_budget = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + 32'(i);
      tick();
      check("abl_addr", 32'(imem_addr), 32'(i));
    end
    abort = 1'b1; s_data = 32'hEE;
    tick();
    abort = 1'b0;
    check("abl_no_write", 32'(imem_we), 32'd0);
    check("abl_done", 32'(done), 32'd1);
    check("abl_status", 32'(status), 32'd3);
    check("abl_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    check("abl_no_write2", 32'(imem_we), 32'd0);
    check("abl_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN acts without a clock edge.
    do_load(2, -1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      core_pc = 32'(16 * i);
      tick();
    end
    check("pre_rst_core", 32'(core_reset), 32'd0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
